ra_64x72_2r1w: RTL and testbench

RA_64X72_2R1W -- requirements
Module: ra_64x72_2r1w

---
 rtl/ra_64x72_2r1w.sv | 51 +++++
 tb/tb_ra_64x72_2r1w.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ra_64x72_2r1w.sv
// 64-word x 72-bit register array with two registered read ports and one write port.
// Reads return the word as it was before the edge, so a same-edge write is seen on the next access.
module ra_64x72_2r1w (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic        rd_enb_0,
  input  logic [0:5]  rd_adr_0,
  output logic [0:71] rd_dat_0,
  input  logic        rd_enb_1,
  input  logic [0:5]  rd_adr_1,
  output logic [0:71] rd_dat_1,
  input  logic        wr_enb_0,
  input  logic [0:5]  wr_adr_0,
  input  logic [0:71] wr_dat_0
);

  logic [0:71] r_mem [0:63];
  logic [0:71] r_rd_dat_0;
  logic [0:71] r_rd_dat_1;
  logic        w_access;
  logic        w_wr;

  assign w_access = strobe & ~reset;
  assign w_wr     = w_access & wr_enb_0;

  // Storage is deliberately left out of reset; only the output registers clear.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[wr_adr_0] <= wr_dat_0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_dat_0 <= '0;
      r_rd_dat_1 <= '0;
    end else if (strobe) begin
      if (rd_enb_0) begin
        r_rd_dat_0 <= r_mem[rd_adr_0];
      end
      if (rd_enb_1) begin
        r_rd_dat_1 <= r_mem[rd_adr_1];
      end
    end
  end

  assign rd_dat_0 = r_rd_dat_0;
  assign rd_dat_1 = r_rd_dat_1;

endmodule

// File: tb/tb_ra_64x72_2r1w.sv
// Directed and randomized checks of ra_64x72_2r1w against an array-based reference model.
// Words never written are tracked as unknown and their read-back is not compared.
module tb_ra_64x72_2r1w;

  logic        clk;
  logic        reset;
  logic        strobe;
  logic        rd_enb_0;
  logic [0:5]  rd_adr_0;
  logic [0:71] rd_dat_0;
  logic        rd_enb_1;
  logic [0:5]  rd_adr_1;
  logic [0:71] rd_dat_1;
  logic        wr_enb_0;
  logic [0:5]  wr_adr_0;
  logic [0:71] wr_dat_0;

  logic [0:71] modelMem [64];
  bit          modelValid [64];
  logic [0:71] exp0;
  logic [0:71] exp1;
  bit          expValid0;
  bit          expValid1;
  int          compareCount;
  int          failCount;
  string       stepName;

  ra_64x72_2r1w dut (
    .clk      (clk),
    .reset    (reset),
    .strobe   (strobe),
    .rd_enb_0 (rd_enb_0),
    .rd_adr_0 (rd_adr_0),
    .rd_dat_0 (rd_dat_0),
    .rd_enb_1 (rd_enb_1),
    .rd_adr_1 (rd_adr_1),
    .rd_dat_1 (rd_dat_1),
    .wr_enb_0 (wr_enb_0),
    .wr_adr_0 (wr_adr_0),
    .wr_dat_0 (wr_dat_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:71] randWord();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[71:0];
  endfunction

  task automatic checkValue(input string tag, input logic [0:71] observed, input logic [0:71] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    if (expValid0) checkValue({stepName, "_p0"}, rd_dat_0, exp0);
    if (expValid1) checkValue({stepName, "_p1"}, rd_dat_1, exp1);
  endtask

  // One clock: drive inputs, advance the model by the access rules, sample 1 ns after the edge.
  task automatic applyStimulus(input logic rst, input logic stb,
                               input logic re0, input logic [0:5] a0,
                               input logic re1, input logic [0:5] a1,
                               input logic we, input logic [0:5] wa, input logic [0:71] wd);
    reset = rst; strobe = stb;
    rd_enb_0 = re0; rd_adr_0 = a0;
    rd_enb_1 = re1; rd_adr_1 = a1;
    wr_enb_0 = we; wr_adr_0 = wa; wr_dat_0 = wd;
    @(posedge clk);
    if (rst) begin
      exp0 = '0; exp1 = '0; expValid0 = 1; expValid1 = 1;
    end else if (stb) begin
      if (re0) begin exp0 = modelMem[a0]; expValid0 = modelValid[a0]; end
      if (re1) begin exp1 = modelMem[a1]; expValid1 = modelValid[a1]; end
      if (we) begin modelMem[wa] = wd; modelValid[wa] = 1; end
    end
    #1;
    checkOutput();
  endtask

  initial begin
    logic [0:71] k;
    compareCount = 0; failCount = 0;
    expValid0 = 0; expValid1 = 0; exp0 = '0; exp1 = '0;
    for (int i = 0; i < 64; i++) begin modelValid[i] = 0; modelMem[i] = '0; end
    reset = 1; strobe = 0; rd_enb_0 = 0; rd_adr_0 = '0; rd_enb_1 = 0; rd_adr_1 = '0;
    wr_enb_0 = 0; wr_adr_0 = '0; wr_dat_0 = '0;

    stepName = "reset";
    applyStimulus(1, 1, 1, 6'd0, 1, 6'd0, 0, 6'd0, '0);
    applyStimulus(1, 1, 1, 6'd0, 1, 6'd0, 0, 6'd0, '0);
    checkValue("reset_p0_zero", rd_dat_0, 72'h0);
    checkValue("reset_p1_zero", rd_dat_1, 72'h0);

    stepName = "wr5";
    applyStimulus(0, 1, 0, 6'd0, 0, 6'd0, 1, 6'd5, 72'h0123456789ABCDEF01);
    stepName = "rd5";
    applyStimulus(0, 1, 1, 6'd5, 1, 6'd5, 0, 6'd0, '0);
    checkValue("rd5_p0_const", rd_dat_0, 72'h0123456789ABCDEF01);
    checkValue("rd5_p1_const", rd_dat_1, 72'h0123456789ABCDEF01);

    stepName = "wr63a";
    applyStimulus(0, 1, 0, 6'd0, 0, 6'd0, 1, 6'd63, {72{1'b1}});
    stepName = "rw63";
    applyStimulus(0, 1, 1, 6'd63, 0, 6'd0, 1, 6'd63, 72'h0);
    checkValue("rw63_old", rd_dat_0, {72{1'b1}});
    stepName = "rd63";
    applyStimulus(0, 1, 1, 6'd63, 0, 6'd0, 0, 6'd0, '0);
    checkValue("rd63_new", rd_dat_0, 72'h0);

    stepName = "wr10";
    applyStimulus(0, 1, 0, 6'd0, 0, 6'd0, 1, 6'd10, {9{8'h11}});
    stepName = "rd10";
    applyStimulus(0, 1, 1, 6'd10, 1, 6'd5, 0, 6'd0, '0);
    stepName = "nostrobe";
    applyStimulus(0, 0, 1, 6'd63, 1, 6'd63, 1, 6'd10, {9{8'hAA}});
    checkValue("nostrobe_hold_p0", rd_dat_0, {9{8'h11}});
    checkValue("nostrobe_hold_p1", rd_dat_1, 72'h0123456789ABCDEF01);
    stepName = "rd10b";
    applyStimulus(0, 1, 1, 6'd10, 0, 6'd0, 0, 6'd0, '0);
    checkValue("rd10_not_aa", rd_dat_0, {9{8'h11}});

    // Fill pass: port 0 ascending, port 1 descending, writing address-pattern data.
    stepName = "fill";
    for (int i = 0; i < 64; i++)
      applyStimulus(0, 1, 1, 6'(i), 1, 6'(63 - i), 1, 6'(i), {9{8'(i)}});
    stepName = "sweep";
    for (int i = 0; i < 64; i++)
      applyStimulus(0, 1, 1, 6'(i), 1, 6'(63 - i), 1, 6'($urandom_range(0, 63)), randWord());

    stepName = "hold3_rd";
    k = modelMem[3];
    applyStimulus(0, 1, 1, 6'd3, 0, 6'd0, 0, 6'd0, '0);
    for (int i = 0; i < 4; i++) begin
      stepName = "hold3";
      applyStimulus(0, 1, 0, 6'd3, 0, 6'd0, 1, 6'd3, randWord());
      checkValue("hold3_const", rd_dat_0, k);
    end

    stepName = "midreset_wr";
    k = randWord();
    applyStimulus(0, 1, 0, 6'd0, 0, 6'd0, 1, 6'd20, k);
    stepName = "midreset";
    applyStimulus(1, 1, 1, 6'd20, 1, 6'd20, 1, 6'd20, ~k);
    checkValue("midreset_zero", rd_dat_0, 72'h0);
    stepName = "midreset_rd";
    applyStimulus(0, 1, 1, 6'd20, 1, 6'd20, 0, 6'd0, '0);
    checkValue("midreset_kept", rd_dat_1, k);

    stepName = "random";
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
                    1'($urandom), 6'($urandom), 1'($urandom), 6'($urandom),
                    1'($urandom), 6'($urandom_range(0, 63)), randWord());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
